// File: rtl/branch_history_update_scheduler.sv
// Write-back update scheduler for the local branch history predictor: FIFO, lookup-conflict
// deferral and full-table clear walk. Define SCHED_BYPASS_EN for same-cycle issue when idle.
module branch_history_update_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned HIST_BITS   = 4,
  parameter int unsigned STALL_LIMIT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       resolve_valid,
  input  logic [15:0]                resolve_pc,
  input  logic                       resolve_taken,
  output logic                       resolve_ready,
  input  logic                       lookup_active,
  input  logic [15:0]                lookup_pc,
  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic                       update_branch_history,
  output logic                       wb_take_jump,
  output logic [15:0]                resolved_pc,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
  localparam int unsigned HistW  = $clog2(HIST_BITS);
  localparam int unsigned ClrW   = INDEX_BITS + HistW;

  localparam logic [CntW-1:0]   DepthC   = CntW'(DEPTH);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT);
  localparam logic [ClrW-1:0]   ClrLast  = '1;

  typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic [ClrW-1:0]   clr_q, clr_d;

  logic [15:0]      pc_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic [15:0] head_pc;
  logic        head_taken;
  logic        in_clear, fifo_empty, conflict, bypass, push, pop;
  logic        unused_lookup_bits;

  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_taken = taken_mem[rd_ptr_q];
  assign in_clear   = (state_q == StClear);
  assign fifo_empty = (count_q == '0);
  assign conflict   = lookup_active && (lookup_pc[INDEX_BITS:1] == head_pc[INDEX_BITS:1]);

  assign unused_lookup_bits = ^{lookup_pc[15:INDEX_BITS+1], lookup_pc[0]};

`ifdef SCHED_BYPASS_EN
  assign bypass = (state_q == StIdle) && fifo_empty && resolve_valid && !flush_req &&
                  !(lookup_active && (lookup_pc[INDEX_BITS:1] == resolve_pc[INDEX_BITS:1]));
`else
  assign bypass = 1'b0;
`endif

  assign resolve_ready = (count_q < DepthC) && !in_clear && !flush_req;
  assign push          = resolve_valid && resolve_ready && !bypass;
  assign flush_busy    = in_clear;
  assign queue_count   = count_q;

  always_comb begin
    update_branch_history = 1'b0;
    wb_take_jump          = 1'b0;
    resolved_pc           = '0;
    pop                   = 1'b0;
    if (in_clear) begin
      // Entry-major walk: the low HistW bits of the counter repeat each entry.
      update_branch_history = 1'b1;
      resolved_pc           = 16'({clr_q[ClrW-1:HistW], 1'b0});
    end else if (bypass) begin
      update_branch_history = 1'b1;
      wb_take_jump          = resolve_taken;
      resolved_pc           = resolve_pc;
    end else if (!fifo_empty && !(conflict && (stall_q < StallMax))) begin
      update_branch_history = 1'b1;
      wb_take_jump          = head_taken;
      resolved_pc           = head_pc;
      pop                   = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    clr_d    = clr_q;
    if (flush_req) begin
      state_d  = StClear;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      stall_d  = '0;
      clr_d    = '0;
    end else if (in_clear) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == ClrLast) state_d = StIdle;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (pop)              stall_d = '0;
      else if (!fifo_empty) stall_d = stall_q + 1'b1;
      state_d = (count_d == '0) ? StIdle : StDrain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
      clr_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      clr_q    <= clr_d;
    end
  end

  // Payload storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resolve_pc;
      taken_mem[wr_ptr_q] <= resolve_taken;
    end
  end

endmodule
